cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL be a direct-mapped, write-back, write-allocate cache between the CPU control/datapath memory port and physical memory. Parameters: none; geometry is fixed.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports, CPU side:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- mem_address  in  16  byte address
- mem_read  in  1  read request, held until mem_resp
- mem_write  in  1  write request, held until mem_resp
- mem_byte_enable  in  2  [1]=high byte, [0]=low byte
- mem_wdata  in  16  write word
- mem_rdata  out  16  read word
- mem_resp  out  1  request complete
REQ-004 Ports, physical-memory side:
- pmem_address  out  16  line address, bits [3:0]=0
- pmem_read  out  1  line read request, held until pmem_resp
- pmem_write  out  1  line write request, held until pmem_resp
- pmem_wdata  out  128  evicted line
- pmem_rdata  in  128  fetched line
- pmem_resp  in  1  line transfer complete

Function
REQ-005 Geometry SHALL be 8 sets x 16-byte lines. Address fields: offset=[3:0], word select=[3:1], index=[6:4], tag=[15:7] (9 bits). mem_address[0] SHALL be ignored.
REQ-006 Per set, the cache SHALL hold valid (1), dirty (1), tag (9) and data (128). Word w SHALL occupy data[16w+15:16w].
REQ-007 Hit SHALL be defined as valid[index] && tag[index]==mem_address[15:7], evaluated combinationally.
REQ-008 The FSM SHALL have the states IDLE, WRITEBACK and ALLOCATE.
REQ-009 IDLE, no request: all outputs SHALL be 0. IDLE with a request and a hit: mem_resp=1 in the same cycle.
- Read hit: mem_rdata = the selected word, same cycle.
- Write hit: the enabled bytes are written and dirty set on that edge.
REQ-010 IDLE, miss with clean or invalid line: go to ALLOCATE. IDLE, miss with valid and dirty line: go to WRITEBACK. mem_resp=0 in both cases.
REQ-011 WRITEBACK SHALL drive:
- pmem_write=1
- pmem_address={stored tag, index, 4'b0}
- pmem_wdata = stored line
On pmem_resp it SHALL go to ALLOCATE and clear dirty.
REQ-012 ALLOCATE SHALL drive pmem_read=1 and pmem_address={mem_address[15:4], 4'b0}. On pmem_resp it SHALL, on the same edge:
- load data from pmem_rdata
- write the tag
- set valid
- clear dirty
- return to IDLE
REQ-013 After a miss the request SHALL complete as a hit in IDLE. Miss latency = writeback wait + allocate wait + 1 cycle.
REQ-014 mem_resp SHALL be asserted only in IDLE, and only on a hit.
REQ-015 pmem_read and pmem_write SHALL never be asserted together.
REQ-016 Byte writes: mem_byte_enable=2'b10 SHALL update only bits [15:8] of the word; 2'b01 only bits [7:0]; 2'b00 SHALL leave data unchanged but still respond and set dirty.
REQ-017 If mem_read and mem_write are both asserted, the request SHALL be treated as a write.
REQ-018 If the CPU drops its request mid-miss, the current pmem transaction SHALL still complete and the line SHALL still be installed.
REQ-019 The CPU address SHALL be sampled combinationally each cycle. The CPU SHALL hold it stable until mem_resp; a change mid-miss is unsupported.

Reset
REQ-020 On rst, the next state SHALL be IDLE and all valid and dirty bits SHALL clear. Tag and data arrays are not reset.
REQ-021 rst asserted in WRITEBACK or ALLOCATE SHALL abort the transaction: pmem_read/pmem_write=0 from the next cycle, and dirty data is discarded.
REQ-022 All outputs SHALL be 0 during and immediately after reset, with no request pending.

Verification
REQ-023 Cold read: reset, then read 0x1234 with pmem returning a line whose word 2 = 0xBEEF after 3 cycles.
- Required: pmem_read, pmem_address=0x1230, then mem_resp with mem_rdata=0xBEEF.
- Required: no pmem_write.
REQ-024 Write hit: after REQ-023, write 0x1236 <- 0xA5A5 with byte_enable 2'b11.
- Required: mem_resp the same cycle.
- Required: a read of 0x1236 returns 0xA5A5 with zero pmem activity.
REQ-025 Byte write: write 0x1237 <- 0x7700 with byte_enable 2'b10.
- Required: a read of 0x1236 returns 0x77A5.
REQ-026 Dirty eviction: read 0x5234 (same index 3, new tag).
- Required: pmem_write with address 0x1230 and wdata word 3 = 0x77A5.
- Required: then pmem_read with address 0x5230, then mem_resp.
- Required: line 3 is clean.
REQ-027 Clean eviction: read 0x1230 after REQ-026.
- Required: pmem_read only, no pmem_write.
REQ-028 Reset mid-allocate: assert rst during ALLOCATE.
- Required: pmem_read=0 next cycle and state IDLE.
- Required: a subsequent read of the same address misses.

Source files
------------

// File: rtl/cache_control_if.sv
// rtl/cache_control_if.sv - CPU-side and physical-memory-side ports of the cache controller
interface cache_control_if;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;

    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_control.sv
// rtl/cache_control.sv - direct-mapped write-back write-allocate cache, 8 sets x 16-byte lines
module cache_control (
    input  logic          clk,
    input  logic          rst,
    cache_control_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     valid_q, dirty_q;
    logic [8:0]     tag_q  [8];
    logic [127:0]   data_q [8];

    logic [8:0]     tag;
    logic [2:0]     index;
    logic [2:0]     word_sel;
    logic [6:0]     bit_base;
    logic           req, hit;
    logic [127:0]   line, line_merged;

    logic           mem_resp, pmem_read, pmem_write;
    logic [15:0]    mem_rdata, pmem_address;
    logic [127:0]   pmem_wdata;
    logic           wr_hit, wb_done, alloc_done;

    assign tag      = bus.mem_address[15:7];
    assign index    = bus.mem_address[6:4];
    assign word_sel = bus.mem_address[3:1];
    assign bit_base = {word_sel, 4'b0000};
    assign req      = bus.mem_read | bus.mem_write;
    assign line     = data_q[index];
    assign hit      = valid_q[index] && (tag_q[index] == tag);

    always_comb begin
        line_merged = line;
        if (bus.mem_byte_enable[0]) line_merged[bit_base +: 8]         = bus.mem_wdata[7:0];
        if (bus.mem_byte_enable[1]) line_merged[bit_base + 7'd8 +: 8]  = bus.mem_wdata[15:8];
    end

    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        // simultaneous read+write is serviced as a write
                        if (!bus.mem_write) mem_rdata = line[bit_base +: 16];
                    end else if (valid_q[index] && dirty_q[index]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[index], index, 4'b0000};
                pmem_wdata   = line;
                if (bus.pmem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {bus.mem_address[15:4], 4'b0000};
                if (bus.pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // reset silences every output so an aborted transfer is dropped at once
        if (rst) begin
            state_d      = IDLE;
            mem_resp     = 1'b0;
            mem_rdata    = 16'h0000;
            pmem_read    = 1'b0;
            pmem_write   = 1'b0;
            pmem_address = 16'h0000;
            pmem_wdata   = '0;
        end
    end

    assign wr_hit     = mem_resp & bus.mem_write;
    assign wb_done    = pmem_write & bus.pmem_resp;
    assign alloc_done = pmem_read & bus.pmem_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 8'h00;
            dirty_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (wr_hit) dirty_q[index] <= 1'b1;
            if (wb_done) dirty_q[index] <= 1'b0;
            if (alloc_done) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_done) begin
            data_q[index] <= bus.pmem_rdata;
            tag_q[index]  <= tag;
        end else if (wr_hit) begin
            data_q[index] <= line_merged;
        end
    end

    assign bus.mem_resp     = mem_resp;
    assign bus.mem_rdata    = mem_rdata;
    assign bus.pmem_read    = pmem_read;
    assign bus.pmem_write   = pmem_write;
    assign bus.pmem_address = pmem_address;
    assign bus.pmem_wdata   = pmem_wdata;
endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - directed vectors for cache_control with a 3-cycle physical memory model
module tb_cache_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_control_if bus();
    cache_control dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic [127:0] pmem [logic [15:0]];

    function automatic logic [127:0] line_at(input logic [15:0] a);
        logic [127:0] l;
        if (pmem.exists(a)) return pmem[a];
        for (int w = 0; w < 8; w++) l[16*w +: 16] = a + 16'(w);
        return l;
    endfunction

    int wait_cnt;
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        wait_cnt       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                wait_cnt = (bus.pmem_read || bus.pmem_write) ? 1 : 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                wait_cnt++;
                if (wait_cnt >= 3) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_read) bus.pmem_rdata = line_at(bus.pmem_address);
                    else pmem[bus.pmem_address] = bus.pmem_wdata;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    int rd_cyc = 0, wr_cyc = 0, both_cyc = 0;
    logic [15:0]  last_rd_addr = 16'h0, last_wr_addr = 16'h0;
    logic [127:0] last_wdata = '0;
    initial forever begin
        @(negedge clk);
        if (bus.pmem_read) begin
            rd_cyc++;
            last_rd_addr = bus.pmem_address;
        end
        if (bus.pmem_write) begin
            wr_cyc++;
            last_wr_addr = bus.pmem_address;
            last_wdata   = bus.pmem_wdata;
        end
        if (bus.pmem_read && bus.pmem_write) both_cyc++;
    end

    task automatic cpu_op(input logic [15:0] a, input logic r, input logic w, input logic [1:0] be,
                          input logic [15:0] wd, output logic [15:0] rd, output int lat);
        logic done;
        @(posedge clk);
        #1;
        bus.mem_address = a; bus.mem_read = r; bus.mem_write = w;
        bus.mem_byte_enable = be; bus.mem_wdata = wd;
        rd = 16'h0; lat = 0; done = 1'b0;
        while (!done && lat < 100) begin
            #1;
            if (bus.mem_resp) begin
                rd = bus.mem_rdata;
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        check("resp_seen", done, 1'b1);
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    endtask

    logic [15:0] rd;
    int lat, rd0, wr0;
    logic [127:0] tmp;

    initial begin
        for (int w = 0; w < 8; w++) tmp[16*w +: 16] = 16'h1000 + 16'(w);
        tmp[47:32] = 16'hBEEF;
        pmem[16'h1230] = tmp;
        bus.mem_address = 16'h0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.mem_byte_enable = 2'b00; bus.mem_wdata = 16'h0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_outs", {bus.mem_resp, bus.mem_rdata, bus.pmem_read, bus.pmem_write, bus.pmem_address}, '0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #3;
        check("idle_outs", {bus.mem_resp, bus.mem_rdata, bus.pmem_read, bus.pmem_write, bus.pmem_address}, '0);
        check("idle_wdata", bus.pmem_wdata, '0);

        // cold read
        rd0 = rd_cyc; wr0 = wr_cyc;
        cpu_op(16'h1234, 1, 0, 2'b11, 16'h0, rd, lat);
        check("cold_rdata", rd, 16'hBEEF);
        check("cold_lat", lat, 4);
        check("cold_rd_cyc", rd_cyc - rd0, 3);
        check("cold_no_wr", wr_cyc - wr0, 0);
        check("cold_addr", last_rd_addr, 16'h1230);

        // write hits and byte enables
        rd0 = rd_cyc; wr0 = wr_cyc;
        cpu_op(16'h1236, 0, 1, 2'b11, 16'hA5A5, rd, lat);
        check("wr_hit_lat", lat, 0);
        cpu_op(16'h1236, 1, 0, 2'b11, 16'h0, rd, lat);
        check("rd_after_wr", rd, 16'hA5A5);
        check("rd_hit_lat", lat, 0);
        check("hit_no_pmem", (rd_cyc - rd0) + (wr_cyc - wr0), 0);
        cpu_op(16'h1237, 0, 1, 2'b10, 16'h7700, rd, lat);
        check("be10_lat", lat, 0);
        cpu_op(16'h1236, 1, 0, 2'b11, 16'h0, rd, lat);
        check("be10_data", rd, 16'h77A5);
        cpu_op(16'h1232, 0, 1, 2'b01, 16'h12CD, rd, lat);
        cpu_op(16'h1232, 1, 0, 2'b11, 16'h0, rd, lat);
        check("be01_data", rd, 16'h10CD);
        cpu_op(16'h1234, 0, 1, 2'b00, 16'hFFFF, rd, lat);
        check("be00_lat", lat, 0);
        cpu_op(16'h1234, 1, 0, 2'b11, 16'h0, rd, lat);
        check("be00_data", rd, 16'hBEEF);
        cpu_op(16'h1238, 1, 1, 2'b11, 16'h4444, rd, lat);
        cpu_op(16'h1238, 1, 0, 2'b11, 16'h0, rd, lat);
        check("rw_as_write", rd, 16'h4444);

        // dirty eviction
        rd0 = rd_cyc; wr0 = wr_cyc;
        cpu_op(16'h5234, 1, 0, 2'b11, 16'h0, rd, lat);
        check("evict_lat", lat, 7);
        check("evict_wr_cyc", wr_cyc - wr0, 3);
        check("evict_rd_cyc", rd_cyc - rd0, 3);
        check("evict_wr_addr", last_wr_addr, 16'h1230);
        check("evict_wdata", last_wdata, 128'h1007_1006_1005_4444_77A5_BEEF_10CD_1000);
        check("evict_rd_addr", last_rd_addr, 16'h5230);
        check("evict_rdata", rd, 16'h5232);

        // clean eviction
        rd0 = rd_cyc; wr0 = wr_cyc;
        cpu_op(16'h1230, 1, 0, 2'b11, 16'h0, rd, lat);
        check("clean_lat", lat, 4);
        check("clean_no_wr", wr_cyc - wr0, 0);
        check("clean_rd_cyc", rd_cyc - rd0, 3);
        check("clean_rdata", rd, 16'h1000);
        cpu_op(16'h1236, 1, 0, 2'b11, 16'h0, rd, lat);
        check("roundtrip", rd, 16'h77A5);

        // request dropped mid-allocate still installs the line
        rd0 = rd_cyc;
        @(posedge clk); #1;
        bus.mem_address = 16'h2250; bus.mem_read = 1'b1;
        @(posedge clk); #3;
        bus.mem_read = 1'b0;
        repeat (6) @(posedge clk);
        cpu_op(16'h2250, 1, 0, 2'b11, 16'h0, rd, lat);
        check("drop_rd_cyc", rd_cyc - rd0, 3);
        check("drop_hit_lat", lat, 0);
        check("drop_rdata", rd, 16'h2250);

        // reset mid-allocate
        @(posedge clk); #1;
        bus.mem_address = 16'h1290; bus.mem_read = 1'b1;
        @(posedge clk); #3;
        check("alloc_started", bus.pmem_read, 1'b1);
        rst = 1'b1; bus.mem_read = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("abort_pmem_read", bus.pmem_read, 1'b0);
        check("abort_resp", bus.mem_resp, 1'b0);
        rd0 = rd_cyc;
        cpu_op(16'h1290, 1, 0, 2'b11, 16'h0, rd, lat);
        check("post_rst_miss", lat, 4);
        check("post_rst_rd_cyc", rd_cyc - rd0, 3);
        check("post_rst_rdata", rd, 16'h1290);
        cpu_op(16'h1230, 1, 0, 2'b11, 16'h0, rd, lat);
        check("valid_cleared", lat, 4);

        check("rd_wr_excl", both_cyc, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
